// File: rtl/avg_pool_divider_pkg.sv
// Shared FSM encoding and width helpers for the window-average divider.
package avg_pool_divider_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_SCALE = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   localparam int ARITH_FLOAT = 0;
   localparam int ARITH_FIXED = 1;

   // Fixed-point accumulator width: headroom for WINDOW full-scale samples, so it never overflows.
   function automatic int acc_width(input int data_width, input int window);
      return data_width + $clog2(window);
   endfunction

endpackage

// File: rtl/avg_pool_divider_scale.sv
// Scale unit: multiplies the window sum by the reciprocal of WINDOW in the selected arithmetic.
module avg_pool_divider_scale
   import avg_pool_divider_pkg::*;
#(
   parameter int                    ARITH_TYPE = 0,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ACC_W      = 32,
   parameter int                    E          = 8,
   parameter int                    M          = 24,
   parameter int                    FRAC       = 10,
   parameter int                    RECIP_FX   = 256,
   parameter logic [DATA_WIDTH-1:0] RECIP_FP   = DATA_WIDTH'(32'h3E800000)
) (
   input  logic [ACC_W-1:0]      acc_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  sat_o
);

   if (ARITH_TYPE == ARITH_FIXED) begin : g_fixed
      localparam int                    PW      = ACC_W + DATA_WIDTH;
      localparam logic [DATA_WIDTH-1:0] RECIP_B = DATA_WIDTH'(RECIP_FX);

      logic [PW-1:0] prod;
      logic          in_range;

      fixed_point_mul #(
         .AW   (ACC_W),
         .BW   (DATA_WIDTH),
         .FRAC (FRAC)
      ) u_mul (
         .a_i (acc_i),
         .b_i (RECIP_B),
         .p_o (prod)
      );

      // Representable iff every bit above the result's sign bit copies that sign bit.
      always_comb begin
         in_range = (&prod[PW-1:DATA_WIDTH-1]) | ~(|prod[PW-1:DATA_WIDTH-1]);
         sat_o    = ~in_range;
         if (in_range) begin
            result_o = prod[DATA_WIDTH-1:0];
         end else if (prod[PW-1]) begin
            result_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         end else begin
            result_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         end
      end
   end else begin : g_float
      floating_point_mul #(
         .E (E),
         .M (M)
      ) u_mul (
         .a_i (acc_i),
         .b_i (RECIP_FP),
         .p_o (result_o)
      );
      assign sat_o = 1'b0;
   end

endmodule

// File: rtl/fixed_point_mul.sv
// Signed fixed-point multiply; the product is arithmetic-shifted right by FRAC (floor rounding).
module fixed_point_mul #(
   parameter int AW   = 18,
   parameter int BW   = 16,
   parameter int FRAC = 10
) (
   input  logic signed [AW-1:0]    a_i,
   input  logic signed [BW-1:0]    b_i,
   output logic signed [AW+BW-1:0] p_o
);
   logic signed [AW+BW-1:0] a_x, b_x, full;

   always_comb begin
      a_x  = (AW+BW)'(a_i);
      b_x  = (AW+BW)'(b_i);
      full = a_x * b_x;
      p_o  = full >>> FRAC;
   end

endmodule

// File: rtl/floating_point_add.sv
// Combinational float add (M counts the hidden bit); truncates, flushes denormals to zero.
module floating_point_add #(
   parameter int E = 8,
   parameter int M = 24
) (
   input  logic [E+M-1:0] a_i,
   input  logic [E+M-1:0] b_i,
   output logic [E+M-1:0] s_o
);
   localparam int W    = E + M;
   localparam int F    = M - 1;
   localparam int EMAX = (1 << E) - 1;

   logic [W-1:0] op_hi, op_lo;
   logic [M-1:0] m_hi, m_lo, m_sh;
   logic [M:0]   sum;
   logic [F-1:0] frac;
   int           e_hi, e_lo, diff, lz, e_res;

   always_comb begin
      if (a_i[W-2:0] >= b_i[W-2:0]) begin
         op_hi = a_i;
         op_lo = b_i;
      end else begin
         op_hi = b_i;
         op_lo = a_i;
      end
      e_hi = int'(op_hi[W-2:F]);
      e_lo = int'(op_lo[W-2:F]);
      m_hi = (e_hi == 0) ? '0 : {1'b1, op_hi[F-1:0]};
      m_lo = (e_lo == 0) ? '0 : {1'b1, op_lo[F-1:0]};
      diff = e_hi - e_lo;
      m_sh = (diff >= M) ? '0 : (m_lo >> diff);
      if (op_hi[W-1] == op_lo[W-1]) begin
         sum = {1'b0, m_hi} + {1'b0, m_sh};
      end else begin
         sum = {1'b0, m_hi} - {1'b0, m_sh};
      end
      lz = M;
      for (int i = 0; i < M; i++) begin
         if (sum[i]) lz = M - 1 - i;
      end
      if (sum[M]) begin
         frac  = F'(sum >> 1);
         e_res = e_hi + 1;
      end else begin
         frac  = F'(sum[M-1:0] << lz);
         e_res = e_hi - lz;
      end
      if (sum == '0 || e_res <= 0) begin
         s_o = '0;
      end else if (e_res >= EMAX) begin
         s_o = {op_hi[W-1], {E{1'b1}}, {F{1'b0}}};
      end else begin
         s_o = {op_hi[W-1], E'(e_res), frac};
      end
   end

endmodule

// File: rtl/floating_point_mul.sv
// Combinational float multiply (M counts the hidden bit); truncates, flushes denormals to zero.
module floating_point_mul #(
   parameter int E = 8,
   parameter int M = 24
) (
   input  logic [E+M-1:0] a_i,
   input  logic [E+M-1:0] b_i,
   output logic [E+M-1:0] p_o
);
   localparam int W    = E + M;
   localparam int F    = M - 1;
   localparam int BIAS = (1 << (E - 1)) - 1;
   localparam int EMAX = (1 << E) - 1;

   logic [2*M-1:0] ma, mb, prod;
   logic [F-1:0]   frac;
   logic           sign;
   int             ea, eb, e_res;

   always_comb begin
      sign  = a_i[W-1] ^ b_i[W-1];
      ea    = int'(a_i[W-2:F]);
      eb    = int'(b_i[W-2:F]);
      ma    = {{M{1'b0}}, 1'b1, a_i[F-1:0]};
      mb    = {{M{1'b0}}, 1'b1, b_i[F-1:0]};
      prod  = ma * mb;
      e_res = ea + eb - BIAS;
      // Product of two [1,2) mantissas lies in [1,4); renormalise by one bit when >= 2.
      if (prod[2*M-1]) begin
         frac  = F'(prod >> M);
         e_res = e_res + 1;
      end else begin
         frac  = F'(prod >> (M - 1));
      end
      if (ea == 0 || eb == 0 || e_res <= 0) begin
         p_o = '0;
      end else if (e_res >= EMAX) begin
         p_o = {sign, {E{1'b1}}, {F{1'b0}}};
      end else begin
         p_o = {sign, E'(e_res), frac};
      end
   end

endmodule

// File: rtl/avg_pool_divider.sv
// Averages each group of WINDOW input samples: accumulate, scale by 1/WINDOW, hold until taken.
module avg_pool_divider
   import avg_pool_divider_pkg::*;
#(
   parameter int                    ARITH_TYPE = 0,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    E          = 8,
   parameter int                    M          = 24,
   parameter int                    FRAC       = 10,
   parameter int                    WINDOW     = 4,
   parameter int                    RECIP_FX   = 256,
   parameter logic [DATA_WIDTH-1:0] RECIP_FP   = DATA_WIDTH'(32'h3E800000)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sat_flag,
   output logic [1:0]            dbg_state_o
);
   localparam int ACC_W = (ARITH_TYPE == ARITH_FIXED) ? acc_width(DATA_WIDTH, WINDOW) : DATA_WIDTH;
   localparam int EXT   = ACC_W - DATA_WIDTH;
   localparam int CW    = $clog2(WINDOW);
   localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [ACC_W-1:0]        acc_q, acc_d, acc_sum;
   logic [DATA_WIDTH-1:0]   out_q, out_d, scaled;
   logic                    sat_q, sat_d, scale_sat;

   if (ARITH_TYPE == ARITH_FIXED) begin : g_acc_fixed
      assign acc_sum = acc_q + {{EXT{in_data[DATA_WIDTH-1]}}, in_data};
   end else begin : g_acc_float
      floating_point_add #(
         .E (E),
         .M (M)
      ) u_add (
         .a_i (acc_q),
         .b_i (in_data),
         .s_o (acc_sum)
      );
   end

   avg_pool_divider_scale #(
      .ARITH_TYPE (ARITH_TYPE),
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (ACC_W),
      .E          (E),
      .M          (M),
      .FRAC       (FRAC),
      .RECIP_FX   (RECIP_FX),
      .RECIP_FP   (RECIP_FP)
   ) u_scale (
      .acc_i    (acc_q),
      .result_o (scaled),
      .sat_o    (scale_sat)
   );

   // Handshake: a word moves only on a rising edge where valid and ready are both 1; valid
   // never depends on ready, and out_data is frozen while out_valid waits for out_ready.
   assign in_ready    = (state_q == ST_ACCUM);
   assign out_valid   = (state_q == ST_HOLD);
   assign out_data    = out_q;
   assign sat_flag    = sat_q;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      out_d   = out_q;
      sat_d   = sat_q;
      case (state_q)
         ST_ACCUM: begin
            if (in_valid) begin
               acc_d = acc_sum;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_SCALE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         ST_SCALE: begin
            out_d   = scaled;
            sat_d   = sat_q | scale_sat;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready) begin
               acc_d   = '0;
               state_d = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ACCUM;
         cnt_q   <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         sat_q   <= sat_d;
      end
   end

endmodule

// File: tb/tb_avg_pool_divider.sv
// Directed bench: two fixed-point instances (1/4 and 1/1 reciprocal) and one float instance.
module tb_avg_pool_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] idata [3];
   logic        ivld  [3];
   logic        ordy  [3];
   logic        ov    [3];
   logic        ir    [3];
   logic        sf    [3];
   logic [1:0]  st    [3];
   logic [15:0] od0, od1;
   logic [31:0] od2;
   int          n_cmp;
   int          n_err;

   always #5 clk = ~clk;

   avg_pool_divider #(
      .ARITH_TYPE (1), .DATA_WIDTH (16), .FRAC (10), .WINDOW (4), .RECIP_FX (256)
   ) u_fx (
      .clk (clk), .rst_n (rst_n), .in_data (idata[0][15:0]), .in_valid (ivld[0]),
      .in_ready (ir[0]), .out_data (od0), .out_valid (ov[0]), .out_ready (ordy[0]),
      .sat_flag (sf[0]), .dbg_state_o (st[0])
   );

   avg_pool_divider #(
      .ARITH_TYPE (1), .DATA_WIDTH (16), .FRAC (10), .WINDOW (4), .RECIP_FX (1024)
   ) u_sat (
      .clk (clk), .rst_n (rst_n), .in_data (idata[1][15:0]), .in_valid (ivld[1]),
      .in_ready (ir[1]), .out_data (od1), .out_valid (ov[1]), .out_ready (ordy[1]),
      .sat_flag (sf[1]), .dbg_state_o (st[1])
   );

   avg_pool_divider u_fp (
      .clk (clk), .rst_n (rst_n), .in_data (idata[2]), .in_valid (ivld[2]),
      .in_ready (ir[2]), .out_data (od2), .out_valid (ov[2]), .out_ready (ordy[2]),
      .sat_flag (sf[2]), .dbg_state_o (st[2])
   );

   function automatic logic [31:0] dout(input int i);
      case (i)
         0:       return {16'h0, od0};
         1:       return {16'h0, od1};
         default: return od2;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic feed(input int i, input logic [31:0] s0, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] s3);
      logic [31:0] s [4];
      s = '{s0, s1, s2, s3};
      for (int k = 0; k < 4; k++) begin
         idata[i] = s[k];
         ivld[i]  = 1'b1;
         step();
      end
      ivld[i] = 1'b0;
   endtask

   // Called right after the edge that took the 4th sample: SCALE now, result visible one edge later.
   task automatic expect_avg(input int i, input string tag, input logic [31:0] exp_data,
                             input logic exp_sat);
      check({tag, ".scale_valid"}, 32'(ov[i]), 32'h0);
      check({tag, ".scale_ready"}, 32'(ir[i]), 32'h0);
      step();
      check({tag, ".valid"}, 32'(ov[i]), 32'h1);
      check({tag, ".data"}, dout(i), exp_data);
      check({tag, ".sat"}, 32'(sf[i]), 32'(exp_sat));
      if (ordy[i]) begin
         step();
         check({tag, ".drop_valid"}, 32'(ov[i]), 32'h0);
         check({tag, ".ready_back"}, 32'(ir[i]), 32'h1);
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s.valid%0d", tag, i), 32'(ov[i]), 32'h0);
         check($sformatf("%s.data%0d", tag, i), dout(i), 32'h0);
         check($sformatf("%s.sat%0d", tag, i), 32'(sf[i]), 32'h0);
         check($sformatf("%s.ready%0d", tag, i), 32'(ir[i]), 32'h1);
         check($sformatf("%s.state%0d", tag, i), 32'(st[i]), 32'h0);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idata[i] = '0;
         ivld[i]  = 1'b0;
         ordy[i]  = 1'b1;
      end
      step();
      step();
      check_reset_state("reset");
      rst_n = 1'b1;

      // 1.0+2.0+3.0+4.0 over 4 -> 2.5
      feed(0, 32'h0400, 32'h0800, 32'h0C00, 32'h1000);
      expect_avg(0, "fx_ramp", 32'h0A00, 1'b0);

      // (-1 -1 -1 + 0)/4 -> -0.75
      feed(0, 32'hFC00, 32'hFC00, 32'hFC00, 32'h0000);
      expect_avg(0, "fx_neg", 32'hFD00, 1'b0);

      // 4 x 0x7FFF at reciprocal 1.0 overflows -> clamp to max, sticky flag
      feed(1, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF);
      expect_avg(1, "fx_sat", 32'h7FFF, 1'b1);
      feed(1, 32'h0400, 32'h0400, 32'h0400, 32'h0400);
      expect_avg(1, "fx_sticky", 32'h1000, 1'b1);

      // float 1,2,3,4 -> 2.5
      feed(2, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
      expect_avg(2, "fp_ramp", 32'h40200000, 1'b0);

      // Backpressure: junk offered during SCALE and 5 stalled HOLD cycles must not be taken
      ordy[0] = 1'b0;
      feed(0, 32'h0400, 32'h0800, 32'h0C00, 32'h1000);
      idata[0] = 32'h7000;
      ivld[0]  = 1'b1;
      check("bp.scale_ready", 32'(ir[0]), 32'h0);
      step();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp.valid%0d", k), 32'(ov[0]), 32'h1);
         check($sformatf("bp.data%0d", k), dout(0), 32'h0A00);
         check($sformatf("bp.ready%0d", k), 32'(ir[0]), 32'h0);
         step();
      end
      check("bp.still_valid", 32'(ov[0]), 32'h1);
      check("bp.still_data", dout(0), 32'h0A00);
      ivld[0] = 1'b0;
      ordy[0] = 1'b1;
      step();
      check("bp.release_valid", 32'(ov[0]), 32'h0);
      check("bp.release_state", 32'(st[0]), 32'h0);
      feed(0, 32'h0800, 32'h0800, 32'h0800, 32'h0800);
      expect_avg(0, "bp_next", 32'h0800, 1'b0);

      // Reset with float result pending in HOLD and fixed window half-filled
      ordy[2] = 1'b0;
      feed(2, 32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000);
      step();
      check("pend.fp_valid", 32'(ov[2]), 32'h1);
      check("pend.fp_data", dout(2), 32'h40800000);
      idata[0] = 32'h0400;
      ivld[0]  = 1'b1;
      step();
      step();
      ivld[0] = 1'b0;
      rst_n   = 1'b0;
      ordy[2] = 1'b1;
      step();
      check_reset_state("midrst");
      rst_n = 1'b1;
      feed(0, 32'h1000, 32'h1000, 32'h1000, 32'h1000);
      expect_avg(0, "rst_clean", 32'h1000, 1'b0);
      feed(2, 32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000);
      expect_avg(2, "rst_clean_fp", 32'h40800000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
